bp_me_nonsynth_lce_tr_replay: RTL and testbench

- Nonsynth trace-replay driver that sits directly upstream of an LCE under test. It produces the trace-replay command stream that the LCE consumes, and it consumes the LCE's trace responses.
- Steps through a trace ROM. Each entry either sends a command packet, waits for and checks a response packet, idles for N cycles, or ends the test.
- Reports done/error to the testbench. The LCE tracer observes the same handshakes.

---
 rtl/bp_me_nonsynth_pkg.sv | 31 +++
 rtl/bp_me_nonsynth_tr_replay_ctr.sv | 41 ++++
 rtl/bp_me_nonsynth_lce_tr_replay.sv | 157 +++++++++++++++
 tb/tb_bp_me_nonsynth_lce_tr_replay.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_me_nonsynth_pkg.sv
// Shared types for the LCE trace-replay driver:
// trace opcodes, FSM states and ROM word sizing.
`ifndef BP_ME_NONSYNTH_PKG_SV
`define BP_ME_NONSYNTH_PKG_SV

`define BP_ME_NONSYNTH_TR_ROM_WIDTH(tr_ring_width) (4 + (tr_ring_width))

package bp_me_nonsynth_pkg;

   localparam int tr_op_width_gp   = 4;
   localparam int tr_wait_width_gp = 16;

   typedef enum logic [3:0] {
      e_tr_op_send = 4'h1
     ,e_tr_op_recv = 4'h2
     ,e_tr_op_wait = 4'h3
     ,e_tr_op_done = 4'h4
   } bp_me_nonsynth_tr_replay_op_e;

   typedef enum logic [2:0] {
      e_st_decode = 3'd0
     ,e_st_send   = 3'd1
     ,e_st_recv   = 3'd2
     ,e_st_wait   = 3'd3
     ,e_st_done   = 3'd4
     ,e_st_error  = 3'd5
   } bp_me_nonsynth_tr_replay_state_e;

endpackage

`endif

// File: rtl/bp_me_nonsynth_tr_replay_ctr.sv
// Loadable up/down counter with async active-low clear.
// Shared by the WAIT countdown and the RECV timeout.
module bp_me_nonsynth_tr_replay_ctr
  #(parameter int width_p = 16
   )
   (input  logic               clk_i
   ,input  logic               reset_n_i
   ,input  logic               clr_i
   ,input  logic               ld_i
   ,input  logic [width_p-1:0] ld_val_i
   ,input  logic               up_i
   ,input  logic               down_i
   ,output logic [width_p-1:0] cnt_o
   );

   logic [width_p-1:0] cnt_q, cnt_d;

   assign cnt_o = cnt_q;

   // Next count: clear beats load beats up beats down
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)
         cnt_d = '0;
      else if (ld_i)
         cnt_d = ld_val_i;
      else if (up_i)
         cnt_d = cnt_q + 1'b1;
      else if (down_i)
         cnt_d = cnt_q - 1'b1;
   end

   // Count register
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

endmodule

// File: rtl/bp_me_nonsynth_lce_tr_replay.sv
// Trace-replay driver feeding an LCE under test: walks a
// trace ROM sending commands, checking responses, idling.
module bp_me_nonsynth_lce_tr_replay
   import bp_me_nonsynth_pkg::*;
  #(parameter int tr_ring_width_p  = 128
   ,parameter int rom_addr_width_p = 10
   ,parameter int timeout_p        = 4096
   ,localparam int rom_width_lp    =
      `BP_ME_NONSYNTH_TR_ROM_WIDTH(tr_ring_width_p)
   )
   (input  logic                        clk_i
   ,input  logic                        reset_n_i
   ,output logic [rom_addr_width_p-1:0] rom_addr_o
   ,input  logic [rom_width_lp-1:0]     rom_data_i
   ,output logic [tr_ring_width_p-1:0]  tr_pkt_o
   ,output logic                        tr_pkt_v_o
   ,input  logic                        tr_pkt_yumi_i
   ,input  logic [tr_ring_width_p-1:0]  tr_pkt_i
   ,input  logic                        tr_pkt_v_i
   ,output logic                        tr_pkt_ready_o
   ,output logic                        done_o
   ,output logic                        error_o
   ,output logic [rom_addr_width_p-1:0] error_pc_o
   );

   localparam int to_width_lp  = $clog2(timeout_p + 1);
   localparam int ctr_width_lp =
      (to_width_lp > tr_wait_width_gp) ? to_width_lp
                                       : tr_wait_width_gp;
   localparam logic [ctr_width_lp-1:0] to_last_lp =
      ctr_width_lp'(timeout_p - 1);

   bp_me_nonsynth_tr_replay_state_e state_q, state_d;

   logic [rom_addr_width_p-1:0] pc_q, pc_d;
   logic [rom_addr_width_p-1:0] err_pc_q, err_pc_d;
   logic [tr_ring_width_p-1:0]  payload_q, payload_d;

   logic [tr_op_width_gp-1:0]  op;
   logic [tr_ring_width_p-1:0] rom_payload;

   logic                    ctr_clr, ctr_ld, ctr_up, ctr_dn;
   logic [ctr_width_lp-1:0] ctr_ld_val, ctr_cnt;
   logic                    advance;

   assign op          = rom_data_i[tr_op_width_gp-1:0];
   assign rom_payload = rom_data_i[rom_width_lp-1:tr_op_width_gp];
   assign ctr_ld_val  =
      ctr_width_lp'(rom_payload[tr_wait_width_gp-1:0]);

   assign rom_addr_o     = pc_q;
   assign tr_pkt_v_o     = (state_q == e_st_send);
   assign tr_pkt_o       = tr_pkt_v_o ? payload_q : '0;
   assign tr_pkt_ready_o = (state_q == e_st_recv);
   assign done_o         = (state_q == e_st_done)
                         | (state_q == e_st_error);
   assign error_o        = (state_q == e_st_error);
   assign error_pc_o     = err_pc_q;

   bp_me_nonsynth_tr_replay_ctr
     #(.width_p(ctr_width_lp))
   ctr
     (.clk_i    (clk_i)
     ,.reset_n_i(reset_n_i)
     ,.clr_i    (ctr_clr)
     ,.ld_i     (ctr_ld)
     ,.ld_val_i (ctr_ld_val)
     ,.up_i     (ctr_up)
     ,.down_i   (ctr_dn)
     ,.cnt_o    (ctr_cnt)
     );

   // Next state, pc advance and counter control
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      err_pc_d  = err_pc_q;
      payload_d = payload_q;
      ctr_clr   = 1'b0;
      ctr_ld    = 1'b0;
      ctr_up    = 1'b0;
      ctr_dn    = 1'b0;
      advance   = 1'b0;

      unique case (state_q)
         e_st_decode: begin
            payload_d = rom_payload;
            case (op)
               e_tr_op_send: state_d = e_st_send;
               e_tr_op_recv: begin
                  state_d = e_st_recv;
                  ctr_clr = 1'b1;
               end
               e_tr_op_wait: begin
                  state_d = e_st_wait;
                  ctr_ld  = 1'b1;
               end
               e_tr_op_done: state_d = e_st_done;
               default: begin
                  state_d  = e_st_error;
                  err_pc_d = pc_q;
               end
            endcase
         end
         e_st_send: advance = tr_pkt_yumi_i;
         e_st_recv: begin
            if (tr_pkt_v_i) begin
               if (tr_pkt_i == payload_q) begin
                  advance = 1'b1;
               end else begin
                  state_d  = e_st_error;
                  err_pc_d = pc_q;
               end
            end else if (ctr_cnt == to_last_lp) begin
               state_d  = e_st_error;
               err_pc_d = pc_q;
            end else begin
               ctr_up = 1'b1;
            end
         end
         e_st_wait: begin
            if (ctr_cnt <= ctr_width_lp'(1))
               advance = 1'b1;
            else
               ctr_dn = 1'b1;
         end
         default: ;
      endcase

      // Running off the end of the ROM never wraps to 0
      if (advance) begin
         if (&pc_q) begin
            state_d  = e_st_error;
            err_pc_d = pc_q;
         end else begin
            pc_d    = pc_q + 1'b1;
            state_d = e_st_decode;
         end
      end
   end

   // State, pc, payload and error pc registers
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q   <= e_st_decode;
         pc_q      <= '0;
         err_pc_q  <= '0;
         payload_q <= '0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         err_pc_q  <= err_pc_d;
         payload_q <= payload_d;
      end
   end

endmodule

// File: tb/tb_bp_me_nonsynth_lce_tr_replay.sv
// Bench for the trace-replay driver: an LCE responder,
// a trace-level reference interpreter and directed ROMs.
module tb_bp_me_nonsynth_lce_tr_replay;

   localparam int W     = 128;
   localparam int AW    = 4;
   localparam int TO    = 16;
   localparam int RW    = W + 4;
   localparam int DEPTH = 1 << AW;

   logic          clk = 1'b0;
   logic          reset_n_i;
   logic [AW-1:0] rom_addr_o;
   logic [RW-1:0] rom_data_i;
   logic [W-1:0]  tr_pkt_o;
   logic          tr_pkt_v_o;
   logic          tr_pkt_yumi_i;
   logic [W-1:0]  tr_pkt_i = '0;
   logic          tr_pkt_v_i = 1'b0;
   logic          tr_pkt_ready_o;
   logic          done_o;
   logic          error_o;
   logic [AW-1:0] error_pc_o;

   logic [RW-1:0] rom [DEPTH];

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // responder configuration and state
   int  yumi_dly = 0;
   int  rsp_dly  = 1;
   bit  rsp_on   = 1'b0;
   int  hold     = 0;
   logic [W-1:0] rsp_q [$];
   int           due_q [$];

   // values latched at negedge for the next posedge
   bit           hs_n = 1'b0;
   bit           rx_n = 1'b0;
   bit           v_n  = 1'b0;
   logic [W-1:0] cmd_n = '0;

   // reference interpreter results
   logic [W-1:0] exp_cmd [$];
   bit           exp_err;
   int           exp_epc;
   int           exp_pc;

   // monitor state
   bit            chk_en = 1'b0;
   int            cmd_idx, v_cyc, rx_cnt, rdy_t0, err_t;
   bit            v_prev, done_prev;
   logic [AW-1:0] v_pc;
   int            hs_cyc [$];
   int            rise_cyc [$];

   always #5 clk = ~clk;

   assign rom_data_i    = rom[rom_addr_o];
   assign tr_pkt_yumi_i = tr_pkt_v_o && (hold >= yumi_dly);

   bp_me_nonsynth_lce_tr_replay
     #(.tr_ring_width_p (W)
      ,.rom_addr_width_p(AW)
      ,.timeout_p       (TO))
   dut
     (.clk_i         (clk)
     ,.reset_n_i     (reset_n_i)
     ,.rom_addr_o    (rom_addr_o)
     ,.rom_data_i    (rom_data_i)
     ,.tr_pkt_o      (tr_pkt_o)
     ,.tr_pkt_v_o    (tr_pkt_v_o)
     ,.tr_pkt_yumi_i (tr_pkt_yumi_i)
     ,.tr_pkt_i      (tr_pkt_i)
     ,.tr_pkt_v_i    (tr_pkt_v_i)
     ,.tr_pkt_ready_o(tr_pkt_ready_o)
     ,.done_o        (done_o)
     ,.error_o       (error_o)
     ,.error_pc_o    (error_pc_o)
     );

   task automatic chk(input string nm,
                      input logic [W-1:0] act,
                      input logic [W-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", nm, act, exp);
      end
   endtask

   task automatic chki(input string nm, input int act,
                       input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0d want=%0d", nm, act, exp);
      end
   endtask

   function automatic logic [RW-1:0] ent(input logic [3:0] op,
                                        input logic [W-1:0] pl);
      return {pl, op};
   endfunction

   task automatic rom_clear();
      for (int i = 0; i < DEPTH; i++) rom[i] = ent(4'h0, '0);
   endtask

   // Trace-level interpreter: what the replay must send and
   // how it must end, given the ROM and the responder's rule
   // (each accepted command comes back as command+1).
   task automatic model_run();
      logic [W-1:0] pend [$];
      logic [W-1:0] pl;
      logic [W-1:0] got;
      logic [3:0]   op;
      int           pc;
      exp_cmd.delete();
      exp_err = 1'b0;
      exp_epc = 0;
      exp_pc  = 0;
      pc      = 0;
      for (int step = 0; step <= DEPTH; step++) begin
         op = rom[pc][3:0];
         pl = rom[pc][RW-1:4];
         if (op == 4'h1) begin
            exp_cmd.push_back(pl);
            if (rsp_on) pend.push_back(pl + W'(1));
         end else if (op == 4'h2) begin
            if (pend.size() == 0) begin
               exp_err = 1'b1; exp_epc = pc; return;
            end
            got = pend.pop_front();
            if (got != pl) begin
               exp_err = 1'b1; exp_epc = pc; return;
            end
         end else if (op == 4'h4) begin
            exp_pc = pc; return;
         end else if (op != 4'h3) begin
            exp_err = 1'b1; exp_epc = pc; return;
         end
         if (pc == DEPTH - 1) begin
            exp_err = 1'b1; exp_epc = pc; return;
         end
         pc++;
      end
   endtask

   // Per-cycle compare against the interpreter's command list
   always @(negedge clk) begin
      hs_n  = 1'b0;
      rx_n  = 1'b0;
      v_n   = 1'b0;
      cmd_n = tr_pkt_o;
      if (reset_n_i) begin
         hs_n = tr_pkt_v_o && tr_pkt_yumi_i;
         rx_n = tr_pkt_v_i && tr_pkt_ready_o;
         v_n  = tr_pkt_v_o;
      end
      if (chk_en && reset_n_i) begin
         if (tr_pkt_v_o) begin
            v_cyc++;
            if (!v_prev) begin
               rise_cyc.push_back(cyc);
               v_pc = rom_addr_o;
            end else begin
               chki("cmd_pc_stable", int'(rom_addr_o), int'(v_pc));
            end
            if (cmd_idx < exp_cmd.size()) begin
               chk("cmd_pkt", tr_pkt_o, exp_cmd[cmd_idx]);
            end else begin
               total++;
               bad++;
               $display("FAIL cmd_extra got=%0h want=none",
                        tr_pkt_o);
            end
            if (tr_pkt_yumi_i) begin
               cmd_idx++;
               hs_cyc.push_back(cyc);
            end
         end
         if (rx_n) rx_cnt++;
         if (tr_pkt_ready_o && rdy_t0 < 0) rdy_t0 = cyc;
         if (error_o && err_t < 0) err_t = cyc;
         chki("err_implies_done", int'(error_o && !done_o), 0);
         if (done_prev) chki("done_sticky", int'(done_o), 1);
         v_prev    = tr_pkt_v_o;
         done_prev = done_o;
      end
   end

   // LCE responder: accepts commands, answers command+1
   always @(posedge clk) begin
      #1;
      cyc++;
      if (!reset_n_i) begin
         rsp_q.delete();
         due_q.delete();
         hold = 0;
      end else begin
         if (hs_n) begin
            hold = 0;
            if (rsp_on) begin
               rsp_q.push_back(cmd_n + W'(1));
               due_q.push_back(cyc + rsp_dly - 1);
            end
         end else if (v_n) begin
            hold++;
         end else begin
            hold = 0;
         end
         if (rx_n && rsp_q.size() > 0) begin
            void'(rsp_q.pop_front());
            void'(due_q.pop_front());
         end
      end
      tr_pkt_v_i = 1'b0;
      tr_pkt_i   = '0;
      if (rsp_q.size() > 0) begin
         tr_pkt_i = rsp_q[0];
         if (due_q[0] <= cyc) tr_pkt_v_i = 1'b1;
      end
   end

   task automatic clear_mon();
      cmd_idx   = 0;
      v_cyc     = 0;
      rx_cnt    = 0;
      v_prev    = 1'b0;
      done_prev = 1'b0;
      rdy_t0    = -1;
      err_t     = -1;
      v_pc      = '0;
      hs_cyc.delete();
      rise_cyc.delete();
   endtask

   task automatic start(input int ydly, input int rdly,
                        input bit ron);
      chk_en = 1'b0;
      @(negedge clk);
      #2;
      reset_n_i = 1'b0;
      yumi_dly  = ydly;
      rsp_dly   = rdly;
      rsp_on    = ron;
      model_run();
      repeat (2) @(negedge clk);
      #2;
      clear_mon();
      chk_en    = 1'b1;
      reset_n_i = 1'b1;
   endtask

   task automatic wait_done(input string nm, input int budget);
      int n;
      n = 0;
      while (!done_o && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (!done_o) begin
         total++;
         bad++;
         $display("FAIL %s_budget done=0 want=1 after %0d",
                  nm, budget);
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic finish_chk(input string nm);
      chki({nm, "_done"}, int'(done_o), 1);
      chki({nm, "_error"}, int'(error_o), int'(exp_err));
      if (exp_err)
         chki({nm, "_epc"}, int'(error_pc_o), exp_epc);
      else
         chki({nm, "_pc"}, int'(rom_addr_o), exp_pc);
      chki({nm, "_ncmd"}, cmd_idx, exp_cmd.size());
   endtask

   initial begin
      logic [W-1:0] a, b, c, d, x;
      int n;
      reset_n_i = 1'b0;
      rom_clear();
      #8;
      chki("rst_addr", int'(rom_addr_o), 0);
      chki("rst_v", int'(tr_pkt_v_o), 0);
      chk("rst_pkt", tr_pkt_o, '0);
      chki("rst_ready", int'(tr_pkt_ready_o), 0);
      chki("rst_done", int'(done_o), 0);
      chki("rst_error", int'(error_o), 0);
      chki("rst_epc", int'(error_pc_o), 0);

      // send, matching response 5 cycles later, done
      a = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
      rom_clear();
      rom[0] = ent(4'h1, a);
      rom[1] = ent(4'h2, a + W'(1));
      rom[2] = ent(4'h4, '0);
      start(0, 5, 1'b1);
      chk("s1_model_cmd0", exp_cmd[0], a);
      wait_done("s1", 100);
      finish_chk("s1");
      chki("s1_vcyc", v_cyc, 1);
      chki("s1_pc_lit", int'(rom_addr_o), 2);
      chki("s1_rx", rx_cnt, 1);

      // yumi held off 7 cycles
      b = 128'h5555_aaaa_0000_ffff_1234_5678_9abc_def0;
      rom_clear();
      rom[0] = ent(4'h1, b);
      rom[1] = ent(4'h4, '0);
      start(7, 1, 1'b0);
      wait_done("s2", 100);
      finish_chk("s2");
      chki("s2_vcyc", v_cyc, 8);
      chki("s2_pc_lit", int'(rom_addr_o), 1);

      // response ...AC where ...AB expected at index 3
      b = 128'hfeed_face_cafe_beef_0000_0000_0000_00ab;
      rom_clear();
      rom[0] = ent(4'h1, b);
      rom[1] = ent(4'h3, W'(2));
      rom[2] = ent(4'h3, '0);
      rom[3] = ent(4'h2, b);
      rom[4] = ent(4'h4, '0);
      start(0, 3, 1'b1);
      chki("s3_model_epc", exp_epc, 3);
      wait_done("s3", 100);
      finish_chk("s3");
      chki("s3_err_lit", int'(error_o), 1);
      chki("s3_epc_lit", int'(error_pc_o), 3);

      // no response: timeout 16 cycles after entering RECV
      rom_clear();
      rom[0] = ent(4'h3, W'(1));
      rom[1] = ent(4'h2, W'(32'h55));
      rom[2] = ent(4'h4, '0);
      start(0, 1, 1'b0);
      wait_done("s4", 100);
      finish_chk("s4");
      chki("s4_epc_lit", int'(error_pc_o), 1);
      chki("s4_to_lat", err_t - rdy_t0, 16);

      // WAIT 10 between sends: low cycles = decode + 10 + decode
      c = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
      d = 128'h9999_aaaa_bbbb_cccc_dddd_eeee_ffff_0000;
      rom_clear();
      rom[0] = ent(4'h1, c);
      rom[1] = ent(4'h3, W'(10));
      rom[2] = ent(4'h1, d);
      rom[3] = ent(4'h4, '0);
      start(0, 1, 1'b0);
      wait_done("s5", 100);
      finish_chk("s5");
      chki("s5_vcyc", v_cyc, 2);
      if (rise_cyc.size() >= 2 && hs_cyc.size() >= 1) begin
         chki("s5_gap", rise_cyc[1] - hs_cyc[0] - 1, 12);
      end else begin
         total++;
         bad++;
         $display("FAIL s5_gap got=%0d/%0d events want=2/1",
                  rise_cyc.size(), hs_cyc.size());
      end

      // illegal opcode at index 0
      rom_clear();
      rom[0] = ent(4'hF, '1);
      start(0, 1, 1'b0);
      wait_done("s6", 20);
      finish_chk("s6");
      chki("s6_epc_lit", int'(error_pc_o), 0);
      chki("s6_err_lit", int'(error_o), 1);

      // reset pulsed in the middle of a pending send
      x = 128'hdead_beef_0bad_f00d_c001_d00d_0123_4567;
      rom_clear();
      rom[0] = ent(4'h3, W'(1));
      rom[1] = ent(4'h1, x);
      rom[2] = ent(4'h4, '0);
      start(1000, 1, 1'b0);
      n = 0;
      while (!tr_pkt_v_o && n < 20) begin
         @(negedge clk);
         n++;
      end
      chki("s7_v_seen", int'(tr_pkt_v_o), 1);
      chki("s7_pc_before", int'(rom_addr_o), 1);
      #2;
      chk_en    = 1'b0;
      reset_n_i = 1'b0;
      #1;
      chki("s7_v_drop", int'(tr_pkt_v_o), 0);
      chki("s7_addr_rst", int'(rom_addr_o), 0);
      chk("s7_pkt_rst", tr_pkt_o, '0);
      repeat (2) @(negedge clk);
      #2;
      yumi_dly = 0;
      clear_mon();
      chk_en    = 1'b1;
      reset_n_i = 1'b1;
      wait_done("s7", 100);
      finish_chk("s7");
      chki("s7_vcyc", v_cyc, 1);
      chki("s7_pc_lit", int'(rom_addr_o), 2);

      // run off the end of the ROM
      rom_clear();
      for (int i = 0; i < DEPTH; i++)
         rom[i] = ent(4'h3, W'(i % 2));
      start(0, 1, 1'b0);
      wait_done("s8", 200);
      finish_chk("s8");
      chki("s8_epc_lit", int'(error_pc_o), DEPTH - 1);

      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
